// File: rtl/homing_pkg.sv
// homing_pkg: channel state encoding and prescaler divisor helper shared by the homing timer.
package homing_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int prescale_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/homing_channel.sv
// homing_channel: one armed delay-then-hold sequencer counting shared timebase ticks.
module homing_channel
  import homing_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             arm,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] hold,
  output logic             enable,
  output logic             done
);

  state_t           state;
  logic [CNT_W-1:0] count;

  // count only decrements from >=2, so a zero count in ACTIVE always means "hold forever"
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      enable <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!arm) begin
        state  <= IDLE;
        enable <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= WAIT;
            count <= delay;
          end
          WAIT: begin
            if (~|count || (tick && count == CNT_W'(1))) begin
              state  <= ACTIVE;
              count  <= hold;
              enable <= 1'b1;
            end else if (tick) begin
              count <= count - CNT_W'(1);
            end
          end
          ACTIVE: begin
            if (tick && |count) begin
              if (count == CNT_W'(1)) begin
                state  <= DONE;
                enable <= 1'b0;
                done   <= 1'b1;
              end else begin
                count <= count - CNT_W'(1);
              end
            end
          end
          DONE: state <= DONE;
        endcase
      end
    end
  end

endmodule

// File: rtl/homing_timer_multi.sv
// homing_timer_multi: N-channel armed delay/hold sequencer sharing one tick prescaler.
// Define HOMING_SYNC_IN_EN to pass each in_enable bit through a 2-flop synchronizer.
module homing_timer_multi
  import homing_pkg::*;
#(
  parameter int CLK_HZ  = 12000000,
  parameter int TICK_HZ = 1,
  parameter int N_CH    = 4,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_enable,
  input  logic [N_CH*CNT_W-1:0] delay,
  input  logic [N_CH*CNT_W-1:0] hold,
  output logic [N_CH-1:0]       enable,
  output logic [N_CH-1:0]       done,
  output logic                  tick
);

  localparam int DIV = prescale_div(CLK_HZ, TICK_HZ);
  localparam int PW  = $clog2(DIV);

  logic [PW-1:0]   pre;
  logic            wrap;
  logic [N_CH-1:0] arm;

  assign wrap = pre == PW'(DIV - 1);

  // free-running so arming never restarts the timebase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre  <= '0;
      tick <= 1'b0;
    end else begin
      pre  <= wrap ? '0 : pre + PW'(1);
      tick <= wrap;
    end
  end

`ifdef HOMING_SYNC_IN_EN
  logic [N_CH-1:0] sync_a, sync_b;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= in_enable;
      sync_b <= sync_a;
    end
  end
  assign arm = sync_b;
`else
  assign arm = in_enable;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    homing_channel #(.CNT_W(CNT_W)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick),
      .arm   (arm[i]),
      .delay (delay[i*CNT_W +: CNT_W]),
      .hold  (hold[i*CNT_W +: CNT_W]),
      .enable(enable[i]),
      .done  (done[i])
    );
  end

endmodule
